// File: rtl/latch_register_if.sv
// Data, control and observation signals of one latch_register on the shared Baby datapath bus.
// With REGISTER_PARITY_EN defined the interface also carries PARITY_STORED.
interface latch_register_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] A;
  logic             LE;
  logic             OE_n;
  logic [WIDTH-1:0] STORED;
`ifdef REGISTER_PARITY_EN
  logic             PARITY_STORED;

  modport master (output A, output LE, output OE_n, input STORED, input PARITY_STORED);
  modport slave  (input A, input LE, input OE_n, output STORED, output PARITY_STORED);
`else
  modport master (output A, output LE, output OE_n, input STORED);
  modport slave  (input A, input LE, input OE_n, output STORED);
`endif
endinterface

// File: rtl/latch_register.sv
// latch_register: '573-style transparent latch with tri-state Q for the shared Baby datapath bus.
// Optional feature macro REGISTER_PARITY_EN adds even-parity outputs Q_PAR (tri-state) and PARITY_STORED.
module latch_register #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic                    clk,
  input  logic                    reset,
  latch_register_if.slave         bus,
  // The tri-state pins stay direct ports so the shared bus resolves in the parent.
  output tri   [WIDTH-1:0]        Q
`ifdef REGISTER_PARITY_EN
  ,
  output tri                      Q_PAR
`endif
);

  logic [WIDTH-1:0] storage_r;
  logic [WIDTH-1:0] out_data_s;

  function automatic logic even_parity(input logic [WIDTH-1:0] word);
    return ^word;
  endfunction

  // Storage word: reset wins over LE; LE captures A on the rising edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      storage_r <= RESET_VALUE;
    end else if (bus.LE) begin
      storage_r <= bus.A;
    end else begin
      storage_r <= storage_r;
    end
  end

  // Output data value: A bypasses the register while transparent, so there is no clock latency.
  always_comb begin
    out_data_s = storage_r;
    if (bus.LE) begin
      out_data_s = bus.A;
    end else begin
      out_data_s = storage_r;
    end
  end

  assign Q          = bus.OE_n ? {WIDTH{1'bz}} : out_data_s;
  assign bus.STORED = storage_r;

`ifdef REGISTER_PARITY_EN
  assign Q_PAR             = bus.OE_n ? 1'bz : even_parity(out_data_s);
  assign bus.PARITY_STORED = even_parity(storage_r);
`endif

endmodule

// File: tb/tb_latch_register.sv
// Scoreboard bench for latch_register: stimulus pushes expected Q/STORED, a negedge monitor pops and compares.
// High-Z on Q is observed by letting the bench drive the bus while OE_n=1; any DUT drive corrupts that value.
module tb_latch_register;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         drive_en;
  logic [W-1:0] drive_val;
  wire  [W-1:0] Q;

  latch_register_if #(.WIDTH(W)) bus();

  assign Q = drive_en ? drive_val : {W{1'bz}};
`ifdef REGISTER_PARITY_EN
  wire Q_PAR;
  assign Q_PAR = drive_en ? 1'b0 : 1'bz;
`endif

  latch_register #(.WIDTH(W), .RESET_VALUE(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .Q     (Q)
`ifdef REGISTER_PARITY_EN
    ,
    .Q_PAR (Q_PAR)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [W-1:0] q;
    logic [W-1:0] stored;
    logic         qpar;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   checks   = 0;
  int   failures = 0;

  // Monitor: every falling edge, compare all pending expectations against the DUT outputs.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      cur = sb.pop_front();
      checks++;
      if (Q !== cur.q) begin
        failures++;
        $display("FAIL %s Q: got %h expected %h", cur.name, Q, cur.q);
      end
      checks++;
      if (bus.STORED !== cur.stored) begin
        failures++;
        $display("FAIL %s STORED: got %h expected %h", cur.name, bus.STORED, cur.stored);
      end
`ifdef REGISTER_PARITY_EN
      checks++;
      if (Q_PAR !== cur.qpar) begin
        failures++;
        $display("FAIL %s Q_PAR: got %b expected %b", cur.name, Q_PAR, cur.qpar);
      end
      checks++;
      if (bus.PARITY_STORED !== ^cur.stored) begin
        failures++;
        $display("FAIL %s PARITY_STORED: got %b expected %b", cur.name, bus.PARITY_STORED, ^cur.stored);
      end
`endif
    end
  end

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  // Queue an expectation; when the bench drives the bus the DUT must be floating, so the bench value is expected.
  task automatic expect_out(input string name, input logic [W-1:0] q, input logic [W-1:0] stored);
    exp_t e;
    e.name   = name;
    e.q      = drive_en ? drive_val : q;
    e.stored = stored;
    e.qpar   = drive_en ? 1'b0 : ^q;
    sb.push_back(e);
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    bus.LE    = 1'b0;
    bus.OE_n  = 1'b0;
    bus.A     = 32'h0000_0000;
    drive_en  = 1'b0;
    drive_val = 32'h5A5A_5A5A;

    after_edge();
    reset = 1'b0;
    expect_out("reset", 32'h0000_0000, 32'h0000_0000);

    bus.A  = 32'h1234_5678;
    bus.LE = 1'b1;
    after_edge();
    expect_out("load", 32'h1234_5678, 32'h1234_5678);

    bus.LE = 1'b0;
    bus.A  = 32'hAAAA_AAAA;
    after_edge();
    expect_out("hold", 32'h1234_5678, 32'h1234_5678);

    bus.LE = 1'b1;
    after_edge();
    expect_out("reload", 32'hAAAA_AAAA, 32'hAAAA_AAAA);

    bus.LE   = 1'b0;
    bus.OE_n = 1'b1;
    drive_en = 1'b1;
    expect_out("tristate", 32'hAAAA_AAAA, 32'hAAAA_AAAA);

    drive_en = 1'b0;
    bus.OE_n = 1'b0;
    expect_out("reenable", 32'hAAAA_AAAA, 32'hAAAA_AAAA);

    after_edge();
    bus.LE = 1'b1;
    bus.A  = 32'h1111_1111;
    expect_out("transp_1", 32'h1111_1111, 32'hAAAA_AAAA);

    after_edge();
    bus.A = 32'h2222_2222;
    expect_out("transp_2", 32'h2222_2222, 32'h1111_1111);

    after_edge();
    bus.A = 32'h0000_0000;
    expect_out("transp_zero", 32'h0000_0000, 32'h2222_2222);

    after_edge();
    bus.A = 32'hFFFF_FFFF;
    expect_out("transp_ones", 32'hFFFF_FFFF, 32'h0000_0000);

    after_edge();
    bus.OE_n = 1'b1;
    bus.A    = 32'h8765_4321;
    drive_en = 1'b1;
    expect_out("load_disabled", 32'h8765_4321, 32'hFFFF_FFFF);

    after_edge();
    drive_en = 1'b0;
    bus.OE_n = 1'b0;
    bus.LE   = 1'b0;
    expect_out("show_loaded", 32'h8765_4321, 32'h8765_4321);

    after_edge();
    bus.LE = 1'b1;
    bus.A  = 32'h5555_5555;
    reset  = 1'b1;
    expect_out("reset_pre", 32'h5555_5555, 32'h8765_4321);

    after_edge();
    expect_out("reset_vs_le", 32'h5555_5555, 32'h0000_0000);

    reset  = 1'b0;
    bus.LE = 1'b0;
    expect_out("reset_hold", 32'h0000_0000, 32'h0000_0000);

    bus.A = 32'hDEAD_BEEF;
    after_edge();
    expect_out("a_ignored", 32'h0000_0000, 32'h0000_0000);

    after_edge();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
